// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: registered PC, waited imem handshake,
// latched delay-slot redirect, exception/eret priority override.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic [2:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] pc_d,
  input  logic [31:0] ext_imm,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc_f,
  output logic [31:0] pc8_d,
  output logic        fetch_valid,
  output logic        adel_f,
  output logic        redirect_pending
);

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JREG   = 3'd3;

  logic [31:0] r_pc_f;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  logic [31:0] w_pc4_d;
  logic [31:0] w_target;
  logic        w_redir_d;
  logic        w_adel;
  logic        w_ready;
  logic [31:0] w_pc_nxt;
  logic        w_pend_valid_nxt;
  logic [31:0] w_pend_target_nxt;

  assign w_pc4_d = pc_d + 32'd4;
  assign pc8_d   = pc_d + 32'd8;

  // Redirect target for the D-stage control-flow op (ops 4-7 fall to SEQ)
  always_comb begin
    w_target = w_pc4_d;
    case (npc_op)
      OP_BRANCH: w_target = w_pc4_d + {ext_imm[29:0], 2'b00};
      OP_JUMP:   w_target = {w_pc4_d[31:28], imm26, 2'b00};
      OP_JREG:   w_target = rs_val;
      default:   w_target = w_pc4_d;
    endcase
  end

  assign w_redir_d = !stall && ((npc_op == OP_BRANCH && br_taken) ||
                                npc_op == OP_JUMP || npc_op == OP_JREG);

  // A faulting fetch never gets a real imem response; let it advance so the
  // exception travels down the pipe.
  assign w_adel  = (r_pc_f[1:0] != 2'b00) || (r_pc_f < IMEM_LO) || (r_pc_f > IMEM_HI);
  assign w_ready = imem_ready || w_adel;

  // Next-state priority: exception > eret > stall > wait > advance
  always_comb begin
    w_pc_nxt          = r_pc_f;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_target_nxt = r_pend_target;
    if (exc_req) begin
      w_pc_nxt         = HANDLER_PC;
      w_pend_valid_nxt = 1'b0;
    end else if (eret) begin
      w_pc_nxt         = epc;
      w_pend_valid_nxt = 1'b0;
    end else if (stall) begin
      w_pc_nxt = r_pc_f;
    end else if (!w_ready) begin
      // Delay slot still in flight: remember the redirect. A redirect from a
      // delay slot (already pending) is dropped; the earlier target wins.
      if (w_redir_d && !r_pend_valid) begin
        w_pend_valid_nxt  = 1'b1;
        w_pend_target_nxt = w_target;
      end
    end else if (r_pend_valid) begin
      w_pc_nxt         = r_pend_target;
      w_pend_valid_nxt = 1'b0;
    end else if (w_redir_d) begin
      w_pc_nxt = w_target;
    end else begin
      w_pc_nxt = r_pc_f + 32'd4;
    end
  end

  // PC and pending-redirect registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_f        <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      r_pc_f        <= w_pc_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_target <= w_pend_target_nxt;
    end
  end

  assign pc_f             = r_pc_f;
  assign redirect_pending = r_pend_valid;
  assign adel_f           = w_adel;
  assign fetch_valid      = !w_adel;

endmodule
